// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Also holds the fetch/decode boundary word and the skid-stage occupancy encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

    // Occupancy as {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b10,
        StFull  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/dffe_sync.sv
// Enable register with synchronous active-high reset to zero.
module dffe_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer.
// in_ready comes straight from the skid valid flop, so decode stalls never reach fetch combinationally.
module if_id_skid_stage #(
    parameter int unsigned XLEN = riscv_pkg::XLEN,
    parameter int unsigned ILEN = riscv_pkg::ILEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
);

    import riscv_pkg::*;

    localparam int unsigned PayW = XLEN + ILEN;

    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [PayW-1:0] main_q, main_d;
    logic [PayW-1:0] skid_q;
    logic            main_load, skid_load;
    logic            in_fire, out_fire;
    skid_state_e     state;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_pc    = main_q[PayW-1:ILEN];
    assign out_instr = main_q[ILEN-1:0];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    always_comb begin
        state        = skid_state_e'({main_valid_q, skid_valid_q});
        main_load    = 1'b0;
        skid_load    = 1'b0;
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        main_d       = {in_pc, in_instr};

        case (state)
            StEmpty: begin
                main_load    = in_fire;
                main_valid_d = in_fire;
            end
            StBusy: begin
                main_load    = in_fire && out_fire;
                skid_load    = in_fire && !out_fire;
                main_valid_d = in_fire || !out_fire;
                skid_valid_d = in_fire && !out_fire;
            end
            StFull: begin
                main_d       = skid_q;
                main_load    = out_fire;
                main_valid_d = 1'b1;
                skid_valid_d = !out_fire;
            end
            default: begin
                // Unreachable encoding: fall back to empty.
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase

        // Redirect drops everything held; payload flops keep their stale contents.
        if (flush) begin
            main_load    = 1'b0;
            skid_load    = 1'b0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    dffe_sync #(.Width(1)) u_main_valid (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (main_valid_d),
        .q   (main_valid_q)
    );

    dffe_sync #(.Width(1)) u_skid_valid (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (skid_valid_d),
        .q   (skid_valid_q)
    );

    dffe_sync #(.Width(PayW)) u_main_payload (
        .clk (clk),
        .rst (rst),
        .en  (main_load),
        .d   (main_d),
        .q   (main_q)
    );

    dffe_sync #(.Width(PayW)) u_skid_payload (
        .clk (clk),
        .rst (rst),
        .en  (skid_load),
        .d   ({in_pc, in_instr}),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: reset, streaming, backpressure, flush, mid-run reset.
module tb_if_id_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    if_id_skid_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Observation vector: {out_valid, in_ready, out_pc, out_instr}.
    function automatic logic [65:0] obs();
        return {out_valid, in_ready, out_pc, out_instr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    task automatic test_reset();
        logic [65:0] exp;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'h40, 32'hdead_beef);
        tick();
        tick();
        exp = {1'b0, 1'b1, 32'h0, 32'h0};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL reset_state got %h exp %h", obs(), exp);
        end
        rst = 1'b0;
        tick();
        exp = {1'b1, 1'b1, 32'h40, 32'hdead_beef};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL reset_first_word got %h exp %h", obs(), exp);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        logic [65:0] exp;
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'h00000013, 32'h00100093, 32'h00200113};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], ins[i]);
            tick();
            exp = {1'b1, 1'b1, pcs[i], ins[i]};
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL stream_%0d got %h exp %h", i, obs(), exp);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stream_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [65:0] exp;
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h0000_000a);
        tick();
        exp = {1'b1, 1'b1, 32'h100, 32'h0000_000a};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL bp_busy got %h exp %h", obs(), exp);
        end
        drive(1'b1, 32'h104, 32'h0000_000b);
        tick();
        drive(1'b1, 32'h108, 32'h0000_000c);
        for (int i = 0; i < 3; i++) begin
            exp = {1'b1, 1'b0, 32'h100, 32'h0000_000a};
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL bp_full_hold_%0d got %h exp %h", i, obs(), exp);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        exp = {1'b1, 1'b1, 32'h104, 32'h0000_000b};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL bp_emit_b got %h exp %h", obs(), exp);
        end
        tick();
        exp = {1'b1, 1'b1, 32'h108, 32'h0000_000c};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL bp_emit_c got %h exp %h", obs(), exp);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [65:0] exp;
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'h0000_0200);
        tick();
        drive(1'b1, 32'h204, 32'h0000_0204);
        out_ready = 1'b1;
        tick();
        exp = {1'b1, 1'b1, 32'h204, 32'h0000_0204};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL b2b_replace got %h exp %h", obs(), exp);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [65:0] exp;
        out_ready = 1'b0;
        drive(1'b1, 32'h2f0, 32'h0000_02f0);
        tick();
        drive(1'b1, 32'h2f4, 32'h0000_02f4);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_pre_full got %b exp 0", in_ready);
        end
        flush = 1'b1;
        drive(1'b1, 32'h300, 32'h0000_0300);
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_leak got %b exp 0", out_valid);
        end
        out_ready = 1'b1;
        drive(1'b1, 32'h310, 32'h0000_0310);
        tick();
        exp = {1'b1, 1'b1, 32'h310, 32'h0000_0310};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL flush_after got %h exp %h", obs(), exp);
        end
        // Flush in BUSY with a live in_fire: the incoming word is dropped, payload kept.
        flush = 1'b1; out_ready = 1'b0;
        drive(1'b1, 32'h320, 32'h0000_0320);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        exp = {1'b0, 1'b1, 32'h310, 32'h0000_0310};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL flush_busy got %h exp %h", obs(), exp);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_busy_drop got %b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0] exp;
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 32'h0000_0400);
        tick();
        drive(1'b1, 32'h404, 32'h0000_0404);
        tick();
        #2;
        rst = 1'b1; flush = 1'b1;
        #1;
        exp = {1'b1, 1'b0, 32'h400, 32'h0000_0400};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL rst_mid_before got %h exp %h", obs(), exp);
        end
        tick();
        exp = {1'b0, 1'b1, 32'h0, 32'h0};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL rst_mid_after got %h exp %h", obs(), exp);
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
